coefficient_loader: RTL and testbench
=====================================

COEFFICIENT_LOADER -- requirements
Module: coefficient_loader

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port new_coeff_set, input, 1: level flag from the host register block; 1 means four new coefficients are ready.
REQ-004 SHALL have port coeff_in, input, 16: coefficient word read from the host register block at index coeff_sel.
REQ-005 SHALL have port modwait, input, 1: busy indication from the downstream FIR filter.
REQ-006 SHALL have port coeff_sel, output, 2: index of the coefficient being read, 0..3.
REQ-007 SHALL have port fir_coefficient, output, 16: registered coefficient word presented to the FIR filter.
REQ-008 SHALL have port load_coeff, output, 1: registered load request to the FIR filter.
REQ-009 SHALL have port clear_new_coeff, output, 1: one-cycle pulse telling the host to clear new_coeff_set.
REQ-010 SHALL have port busy, output, 1: high while a load sequence is in progress.
REQ-011 SHALL have port timeout_err, output, 1: sticky handshake-timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, LOAD, WAIT_DONE, CLEAR and ERROR, plus a 2-bit index register idx and a 4-bit timer.
REQ-013 IDLE SHALL go to SETUP with idx=0 when new_coeff_set=1 and modwait=0, and SHALL stay in IDLE otherwise.
REQ-014 coeff_sel SHALL equal idx combinationally in every state.
REQ-015 In SETUP, fir_coefficient SHALL capture coeff_in at the clock edge, and the FSM SHALL go to LOAD on that same edge.
REQ-016 In LOAD, load_coeff SHALL be 1 and fir_coefficient SHALL be held; on modwait=1 the FSM SHALL go to WAIT_DONE.
REQ-017 In WAIT_DONE, load_coeff SHALL be 0; on modwait=0, the FSM SHALL go to CLEAR if idx=3, else to SETUP with idx incremented by 1.
REQ-018 CLEAR SHALL assert clear_new_coeff for exactly one cycle and then go to IDLE.
REQ-019 load_coeff SHALL be a registered output, asserted from the first LOAD cycle through the last LOAD cycle with no glitches.
REQ-020 Latency: with new_coeff_set=1 sampled at edge n, SETUP SHALL be active in cycle n+1 and load_coeff SHALL be 1 from cycle n+2.
REQ-021 The timer SHALL be cleared on entry to LOAD and on entry to WAIT_DONE.
REQ-022 The timer SHALL increment each cycle spent in LOAD or WAIT_DONE; if it reaches 15 with the exit condition still false, the next state SHALL be ERROR.
REQ-023 In ERROR, timeout_err SHALL be 1, load_coeff SHALL be 0 and busy SHALL be 0.
REQ-024 ERROR SHALL go to IDLE only when new_coeff_set=0; timeout_err SHALL clear on that transition.
REQ-025 busy SHALL be 1 in SETUP, LOAD, WAIT_DONE and CLEAR, and 0 in IDLE and ERROR.
REQ-026 Once a sequence starts, deasserting new_coeff_set SHALL be ignored; all four coefficients (idx 0..3) SHALL still be loaded.
REQ-027 After CLEAR, if new_coeff_set is still 1 in the IDLE cycle, a new sequence SHALL start; the host is responsible for clearing the flag.
REQ-028 A modwait=1 pulse while in SETUP SHALL NOT be treated as an acknowledge; only modwait seen in LOAD counts.
REQ-029 idx SHALL NOT wrap past 3 within a sequence; the idx=3 completion in WAIT_DONE SHALL route to CLEAR, never to SETUP.

Reset
REQ-030 rst=1 SHALL, asynchronously: set the state to IDLE; set idx, timer and coeff_sel to 0; set fir_coefficient to 0x0000; set load_coeff, clear_new_coeff, busy and timeout_err to 0.
REQ-031 rst asserted mid-sequence SHALL abort the sequence immediately with no clear_new_coeff pulse; after rst falls, a still-high new_coeff_set SHALL restart the sequence from idx=0.

Verification
REQ-032 Nominal load: new_coeff_set=1; coeff_in values 0x0001, 0x0002, 0x0003, 0x0004 for idx 0..3; model modwait rising 3 cycles after load_coeff and lasting 4 cycles.
  -> Four load_coeff pulses, with fir_coefficient = 0x0001, 0x0002, 0x0003, 0x0004 in order.
  -> Exactly one clear_new_coeff pulse.
  -> busy falls one cycle after CLEAR.
REQ-033 Timeout: modwait held at 0 after the first load_coeff.
  -> After 15 LOAD cycles the FSM enters ERROR, with timeout_err=1 and load_coeff=0.
  -> With new_coeff_set=0, the FSM returns to IDLE and timeout_err=0.
REQ-034 Flag dropped mid-sequence: new_coeff_set falls during idx=1.
  -> All four loads still occur, followed by one clear_new_coeff pulse.
REQ-035 Start gating: new_coeff_set=1 while modwait=1.
  -> The FSM stays in IDLE and load_coeff stays 0 until modwait=0.
  -> SETUP follows on the next cycle.
REQ-036 Reset abort: rst=1 while in WAIT_DONE with idx=2.
  -> All outputs read 0 immediately and clear_new_coeff never pulses.
  -> After release with new_coeff_set=1, loading restarts at coeff_sel=0.

Source files
------------

// File: rtl/coefficient_loader.sv
// -----------------------------------------------------------------------------
// coefficient_loader
//
// Copies a set of four 16-bit coefficients from the host register block into
// a downstream FIR filter, one word at a time, using the filter's modwait
// busy signal as the acknowledge.
//
// Ports
//   clk             : system clock, all state changes on the rising edge
//   rst             : asynchronous, active-high reset
//   new_coeff_set   : host flag, 1 = four new coefficients are waiting
//   coeff_in        : host coefficient word at index coeff_sel
//   modwait         : FIR busy indication (acknowledge of a load request)
//   coeff_sel       : index (0..3) of the coefficient currently addressed
//   fir_coefficient : registered coefficient word presented to the FIR
//   load_coeff      : registered load request to the FIR
//   clear_new_coeff : one-cycle pulse asking the host to clear its flag
//   busy            : 1 while a load sequence is in progress
//   timeout_err     : 1 while parked in ERROR after a handshake timeout
//   state_dbg       : current FSM state, for debug and checker binding
//
// Handshake: load_coeff acts as "valid". It rises together with a stable
// fir_coefficient and stays high until the FIR raises modwait; modwait seen
// high while in LOAD is the only accepted acknowledge. The word is complete
// once modwait drops again. Each of these two waits is bounded to 15 cycles;
// exceeding either one parks the FSM in ERROR until the host drops its flag.
// -----------------------------------------------------------------------------
module coefficient_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_coeff_set,
    input  logic [15:0] coeff_in,
    input  logic        modwait,
    output logic [1:0]  coeff_sel,
    output logic [15:0] fir_coefficient,
    output logic        load_coeff,
    output logic        clear_new_coeff,
    output logic        busy,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        LOAD      = 3'd2,
        WAIT_DONE = 3'd3,
        CLEAR     = 3'd4,
        ERROR     = 3'd5
    } state_t;

    // The timer holds 0 in the first cycle of LOAD/WAIT_DONE, so the value
    // 14 marks the 15th cycle; failing to exit there moves the timer to 15
    // and the FSM to ERROR.
    localparam logic [3:0] TIMER_LAST = 4'd14;

    state_t      state;
    logic [1:0]  idx;
    logic [3:0]  timer;

    assign coeff_sel = idx;
    assign state_dbg = state;

    // All outputs are registered alongside the state so each one is a clean
    // function of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= 2'd0;
            timer           <= 4'd0;
            fir_coefficient <= 16'h0000;
            load_coeff      <= 1'b0;
            clear_new_coeff <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A busy FIR blocks the start of a new sequence.
                    if (new_coeff_set && !modwait) begin
                        state <= SETUP;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                    end
                end

                SETUP: begin
                    // modwait is deliberately ignored here.
                    fir_coefficient <= coeff_in;
                    state           <= LOAD;
                    load_coeff      <= 1'b1;
                    timer           <= 4'd0;
                end

                LOAD: begin
                    if (modwait) begin
                        state      <= WAIT_DONE;
                        load_coeff <= 1'b0;
                        timer      <= 4'd0;
                    end else if (timer == TIMER_LAST) begin
                        state       <= ERROR;
                        load_coeff  <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        timer       <= timer + 4'd1;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end

                WAIT_DONE: begin
                    if (!modwait) begin
                        // idx never wraps: the last word always ends in CLEAR.
                        if (idx == 2'd3) begin
                            state           <= CLEAR;
                            clear_new_coeff <= 1'b1;
                        end else begin
                            state <= SETUP;
                            idx   <= idx + 2'd1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state       <= ERROR;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        timer       <= timer + 4'd1;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end

                CLEAR: begin
                    state           <= IDLE;
                    clear_new_coeff <= 1'b0;
                    busy            <= 1'b0;
                    idx             <= 2'd0;
                end

                ERROR: begin
                    // Stay parked until the host withdraws the request.
                    if (!new_coeff_set) begin
                        state       <= IDLE;
                        timeout_err <= 1'b0;
                        idx         <= 2'd0;
                    end
                end

                default: begin
                    state           <= IDLE;
                    idx             <= 2'd0;
                    timer           <= 4'd0;
                    load_coeff      <= 1'b0;
                    clear_new_coeff <= 1'b0;
                    busy            <= 1'b0;
                    timeout_err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coefficient_loader.sv
// -----------------------------------------------------------------------------
// tb_coefficient_loader
//
// The host register block is modelled as a 4-entry array read through
// coeff_sel; the FIR is modelled as a responder that raises modwait a chosen
// number of cycles after each load request and holds it for a chosen length.
// Every expected coefficient is queued as {index, word} when a sequence is
// started and popped on each rising edge of load_coeff.
// -----------------------------------------------------------------------------
module tb_coefficient_loader;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        new_coeff_set;
    logic [15:0] coeff_in;
    logic        modwait;
    logic [1:0]  coeff_sel;
    logic [15:0] fir_coefficient;
    logic        load_coeff;
    logic        clear_new_coeff;
    logic        busy;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    coefficient_loader dut (
        .clk             (clk),
        .rst             (rst),
        .new_coeff_set   (new_coeff_set),
        .coeff_in        (coeff_in),
        .modwait         (modwait),
        .coeff_sel       (coeff_sel),
        .fir_coefficient (fir_coefficient),
        .load_coeff      (load_coeff),
        .clear_new_coeff (clear_new_coeff),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .state_dbg       (state_dbg)
    );

    // Host register block: combinational read at coeff_sel.
    logic [15:0] host_regs [4];
    always_comb coeff_in = host_regs[coeff_sel];

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] exp_q [$];
    int          seq_loads  = 0;
    int          seq_clears = 0;
    logic        prev_load  = 1'b0;
    logic [15:0] held_coef  = 16'h0;

    // FIR responder settings
    bit fir_auto = 1'b0;
    int fir_cnt  = 1000;
    int ack_dly  = 3;
    int ack_len  = 4;

    typedef struct {
        logic [63:0] coeffs;    // {c3, c2, c1, c0}; expected fir words in order
        int          dly;       // cycles from load_coeff rise to modwait rise
        int          len;       // cycles modwait stays high
        int          drop_idx;  // idx during which host drops the flag, -1 none
    } vec_t;

    vec_t vecs [4];

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_set();
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), host_regs[i]});
    endtask

    // One clock: sample 1 time unit after the edge, score, then drive modwait.
    task automatic tick();
        logic [17:0] e;
        @(posedge clk);
        #1;
        if (load_coeff && !prev_load) begin
            seq_loads++;
            held_coef = fir_coefficient;
            fir_cnt   = 0;
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'(load_coeff), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("load_sel",  32'(coeff_sel),       32'(e[17:16]));
                check("load_word", 32'(fir_coefficient), 32'(e[15:0]));
            end
        end else begin
            if (load_coeff && prev_load)
                check("load_hold", 32'(fir_coefficient), 32'(held_coef));
            if (fir_cnt < 1000) fir_cnt++;
        end
        if (clear_new_coeff) seq_clears++;
        prev_load = load_coeff;
        check("inv_load_busy", 32'(load_coeff & ~busy), 32'd0);
        check("inv_err_busy",  32'(timeout_err & busy), 32'd0);
        if (fir_auto) modwait = (fir_cnt >= ack_dly) && (fir_cnt < ack_dly + ack_len);
    endtask

    task automatic begin_seq();
        seq_loads  = 0;
        seq_clears = 0;
        push_set();
        new_coeff_set = 1'b1;
    endtask

    // Runs to the clear pulse and checks the end of a sequence.
    task automatic finish_seq(input string tag, input int drop_idx, input bit drop_on_clear);
        int budget;
        budget = 0;
        while (seq_clears == 0 && budget < 300) begin
            tick();
            budget++;
            if (drop_idx >= 0 && seq_loads == drop_idx + 1) new_coeff_set = 1'b0;
        end
        check({tag, "_clear_seen"}, 32'(seq_clears), 32'd1);
        check({tag, "_loads"}, 32'(seq_loads), 32'd4);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_in_clear"}, 32'(busy), 32'd1);
        if (drop_on_clear) new_coeff_set = 1'b0;
        tick();
        check({tag, "_clear_one_cycle"}, 32'(clear_new_coeff), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_seq(input string tag, input logic [63:0] coeffs,
                           input int dly, input int len, input int drop_idx);
        for (int i = 0; i < 4; i++) host_regs[i] = coeffs[16*i +: 16];
        ack_dly  = dly;
        ack_len  = len;
        fir_auto = 1'b1;
        modwait  = 1'b0;
        begin_seq();
        tick();
        check({tag, "_setup_busy"}, 32'(busy), 32'd1);
        check({tag, "_setup_noload"}, 32'(load_coeff), 32'd0);
        check({tag, "_setup_sel"}, 32'(coeff_sel), 32'd0);
        tick();
        check({tag, "_load_latency"}, 32'(load_coeff), 32'd1);
        finish_seq(tag, drop_idx, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;

        vecs[0] = '{64'h0004_0003_0002_0001, 3, 4, -1};
        vecs[1] = '{64'hFFFF_8000_0001_0000, 1, 1, -1};
        vecs[2] = '{64'hA5A5_5A5A_DEAD_BEEF, 5, 2,  1};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 2, 6,  0};

        rst           = 1'b1;
        new_coeff_set = 1'b0;
        modwait       = 1'b0;
        for (int i = 0; i < 4; i++) host_regs[i] = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sel",     32'(coeff_sel),       32'd0);
        check("rst_word",    32'(fir_coefficient), 32'd0);
        check("rst_load",    32'(load_coeff),      32'd0);
        check("rst_clear",   32'(clear_new_coeff), 32'd0);
        check("rst_busy",    32'(busy),            32'd0);
        check("rst_timeout", 32'(timeout_err),     32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven nominal and flag-drop sequences.
        foreach (vecs[k]) run_seq($sformatf("vec%0d", k), vecs[k].coeffs,
                                  vecs[k].dly, vecs[k].len, vecs[k].drop_idx);

        // Timeout in LOAD: modwait never rises.
        fir_auto = 1'b0;
        modwait  = 1'b0;
        for (int i = 0; i < 4; i++) host_regs[i] = 16'h1111 * 16'(i + 1);
        begin_seq();
        tick();
        tick();
        n = 0;
        while (load_coeff && n < 40) begin
            n++;
            tick();
        end
        check("to_load_cycles", 32'(n), 32'd15);
        check("to_load_err",    32'(timeout_err), 32'd1);
        check("to_load_lc",     32'(load_coeff),  32'd0);
        check("to_load_busy",   32'(busy),        32'd0);
        exp_q.delete();
        repeat (3) tick();
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        new_coeff_set = 1'b0;
        tick();
        check("to_err_cleared", 32'(timeout_err), 32'd0);
        check("to_idle_busy",   32'(busy),        32'd0);

        // Timeout in WAIT_DONE: modwait rises and never falls.
        begin_seq();
        tick();
        tick();
        modwait = 1'b1;
        tick();
        check("tw_wait_lc",   32'(load_coeff), 32'd0);
        check("tw_wait_busy", 32'(busy),       32'd1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("tw_wait_cycles", 32'(n), 32'd15);
        check("tw_err",         32'(timeout_err), 32'd1);
        exp_q.delete();
        new_coeff_set = 1'b0;
        modwait       = 1'b0;
        tick();
        check("tw_err_cleared", 32'(timeout_err), 32'd0);

        // Start gating: FIR busy holds off the sequence.
        modwait = 1'b1;
        for (int i = 0; i < 4; i++) host_regs[i] = 16'hC000 + 16'(i);
        begin_seq();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gate_busy", 32'(busy),       32'd0);
            check("gate_load", 32'(load_coeff), 32'd0);
        end
        modwait = 1'b0;
        tick();
        check("gate_setup", 32'(busy), 32'd1);
        ack_dly  = 2;
        ack_len  = 2;
        fir_auto = 1'b1;
        tick();
        check("gate_load_on", 32'(load_coeff), 32'd1);
        finish_seq("gate", -1, 1'b1);

        // modwait pulse during SETUP is not an acknowledge.
        fir_auto = 1'b0;
        modwait  = 1'b0;
        for (int i = 0; i < 4; i++) host_regs[i] = 16'h0F00 + 16'(i);
        begin_seq();
        tick();
        modwait = 1'b1;
        tick();
        check("setup_pulse_load", 32'(load_coeff), 32'd1);
        modwait = 1'b0;
        tick();
        check("setup_pulse_still_load", 32'(load_coeff), 32'd1);
        ack_dly  = 2;
        ack_len  = 2;
        fir_auto = 1'b1;
        finish_seq("setup_pulse", -1, 1'b1);

        // Flag left high after CLEAR: a second sequence starts.
        for (int i = 0; i < 4; i++) host_regs[i] = 16'h2000 + 16'(i);
        ack_dly = 3;
        ack_len = 1;
        begin_seq();
        finish_seq("rst1", -1, 1'b0);
        for (int i = 0; i < 4; i++) host_regs[i] = 16'h3000 + 16'(i);
        begin_seq();
        tick();
        check("restart_setup", 32'(busy), 32'd1);
        check("restart_sel",   32'(coeff_sel), 32'd0);
        finish_seq("restart", -1, 1'b1);

        // Reset abort in WAIT_DONE at idx 2.
        for (int i = 0; i < 4; i++) host_regs[i] = 16'h4440 + 16'(i);
        ack_dly = 2;
        ack_len = 3;
        begin_seq();
        n = 0;
        do begin
            tick();
            n++;
        end while (!(seq_loads == 3 && !load_coeff && busy) && n < 200);
        check("abort_reached", 32'(n < 200), 32'd1);
        check("abort_sel_before", 32'(coeff_sel), 32'd2);
        rst = 1'b1;
        #1;
        check("abort_word",  32'(fir_coefficient), 32'd0);
        check("abort_load",  32'(load_coeff),      32'd0);
        check("abort_busy",  32'(busy),            32'd0);
        check("abort_clear", 32'(clear_new_coeff), 32'd0);
        check("abort_to",    32'(timeout_err),     32'd0);
        check("abort_sel",   32'(coeff_sel),       32'd0);
        fir_auto = 1'b0;
        modwait  = 1'b0;
        fir_cnt  = 1000;
        exp_q.delete();
        repeat (2) tick();
        check("abort_no_clear", 32'(seq_clears), 32'd0);
        rst = 1'b0;
        fir_auto = 1'b1;
        begin_seq();
        tick();
        check("abort_restart_busy", 32'(busy), 32'd1);
        check("abort_restart_sel",  32'(coeff_sel), 32'd0);
        finish_seq("abort_restart", -1, 1'b1);

        // Randomized sequences.
        for (int r = 0; r < 20; r++) begin
            run_seq($sformatf("rnd%0d", r), {$urandom(), $urandom()},
                    int'($urandom_range(1, 10)), int'($urandom_range(1, 8)),
                    int'($urandom_range(0, 4)) - 1);
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
